// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the four-channel DMA request arbiter.
// Covers FSM states, channel transfer-mode encodings and command register bit positions.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_DEMAND  = 2'b00;
  localparam logic [1:0] MODE_SINGLE  = 2'b01;
  localparam logic [1:0] MODE_BLOCK   = 2'b10;
  localparam logic [1:0] MODE_CASCADE = 2'b11;

  localparam int CMD_DISABLE   = 2;
  localparam int CMD_ROTATE    = 4;
  localparam int CMD_DREQ_LOW  = 6;
  localparam int CMD_DACK_HIGH = 7;

  function automatic logic [3:0] onehot4(input logic [1:0] ch);
    onehot4 = 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Connects the arbiter to the pins, the register file and the timing-control FSM.
// The master side drives requests and status; the slave side is the arbiter.
interface dma_priority_arbiter_if;
  logic [3:0] DREQ;
  logic [7:0] commandReg;
  logic [3:0] maskReg;
  logic [3:0] requestReg;
  logic [7:0] modeSel;
  logic       validDACK;
  logic       cycleDone;
  logic       eopIn;
  logic [3:0] VALID_DREQ;
  logic [1:0] activeCh;
  logic       busy;
  logic [3:0] DACK;
  logic [3:0] reqStatus;
  logic [3:0] requestClr;

  modport master (
    output DREQ, commandReg, maskReg, requestReg, modeSel, validDACK, cycleDone, eopIn,
    input  VALID_DREQ, activeCh, busy, DACK, reqStatus, requestClr
  );

  modport slave (
    input  DREQ, commandReg, maskReg, requestReg, modeSel, validDACK, cycleDone, eopIn,
    output VALID_DREQ, activeCh, busy, DACK, reqStatus, requestClr
  );
endinterface

// File: rtl/dma_priority_encoder.sv
// Picks the highest-priority pending channel, searching from rotPtr when rotating
// and from channel 0 otherwise.
module dma_priority_encoder (
  input  logic [3:0] pending,
  input  logic [1:0] rotPtr,
  input  logic       rotate,
  output logic [1:0] winner,
  output logic       anyReq
);

  logic [1:0] base;
  logic [1:0] idx;

  // Descending scan: the last hit written is the one closest to the search base.
  always_comb begin
    base   = rotate ? rotPtr : 2'd0;
    winner = 2'd0;
    idx    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (pending[idx]) winner = idx;
    end
  end

  assign anyReq = |pending;

endmodule

// File: rtl/dma_priority_arbiter.sv
// Four-channel DMA request arbiter and channel sequencer: arbitrates pending requests,
// holds the grant per transfer mode and drives the DACK pins.
module dma_priority_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  dma_priority_arbiter_if.slave bus
);

  state_t     state_reg, state_next;
  logic [1:0] active_reg, active_next;
  logic [1:0] rot_ptr_reg, rot_ptr_next;
  logic       hold_reg, hold_next;
  logic [3:0] dreq_q_reg;
  logic [3:0] dack_reg, dack_next;
  logic [3:0] request_clr_reg, request_clr_next;

  logic [3:0] hw_req;
  logic [3:0] pending;
  logic [1:0] winner;
  logic       any_req;
  logic [1:0] cur_mode;
  logic       keep;
  logic       dack_on;

  assign hw_req   = (bus.commandReg[CMD_DREQ_LOW] ? ~dreq_q_reg : dreq_q_reg) & ~bus.maskReg;
  assign pending  = hw_req | bus.requestReg;
  assign cur_mode = bus.modeSel[{active_reg, 1'b0} +: 2];

  dma_priority_encoder u_enc (
    .pending (pending),
    .rotPtr  (rot_ptr_reg),
    .rotate  (bus.commandReg[CMD_ROTATE]),
    .winner  (winner),
    .anyReq  (any_req)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg       <= ST_IDLE;
      active_reg      <= 2'd0;
      rot_ptr_reg     <= 2'd0;
      hold_reg        <= 1'b0;
      dreq_q_reg      <= 4'b0000;
      dack_reg        <= 4'b1111;
      request_clr_reg <= 4'b0000;
    end else begin
      state_reg       <= state_next;
      active_reg      <= active_next;
      rot_ptr_reg     <= rot_ptr_next;
      hold_reg        <= hold_next;
      dreq_q_reg      <= bus.DREQ;
      dack_reg        <= dack_next;
      request_clr_reg <= request_clr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    active_next = active_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (!bus.commandReg[CMD_DISABLE] && any_req) begin
          state_next  = ST_GRANT;
          active_next = winner;
        end
      end
      ST_GRANT: begin
        if (bus.eopIn)                   state_next = ST_IDLE;
        else if (!pending[active_reg])   state_next = ST_IDLE;
        else if (bus.validDACK)          state_next = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (bus.eopIn) begin
          state_next = ST_IDLE;
        end else if (bus.cycleDone) begin
          case (cur_mode)
            MODE_SINGLE, MODE_CASCADE: state_next = ST_IDLE;
            MODE_BLOCK:                state_next = ST_GRANT;
            default:                   state_next = pending[active_reg] ? ST_GRANT : ST_IDLE;
          endcase
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A GRANT re-entered from SERVICE keeps DACK asserted so multi-cycle transfers see no gap.
  always_comb begin
    keep             = (state_reg == ST_SERVICE) || ((state_reg == ST_GRANT) && hold_reg);
    hold_next        = (state_next == ST_GRANT) && keep;
    dack_on          = (state_next == ST_SERVICE) || hold_next;
    rot_ptr_next     = ((state_reg == ST_SERVICE) && (state_next != ST_SERVICE)) ?
                       active_reg + 2'd1 : rot_ptr_reg;
    request_clr_next = ((state_reg == ST_SERVICE) && bus.eopIn) ? onehot4(active_reg) : 4'b0000;
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_dack
    assign dack_next[gi] = (dack_on && (active_next == 2'(gi))) ~^ bus.commandReg[CMD_DACK_HIGH];
  end

  assign bus.VALID_DREQ = (state_reg == ST_GRANT) ? onehot4(active_reg) : 4'b0000;
  assign bus.activeCh   = active_reg;
  assign bus.busy       = (state_reg != ST_IDLE);
  assign bus.DACK       = dack_reg;
  assign bus.reqStatus  = pending;
  assign bus.requestClr = request_clr_reg;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for the DMA priority arbiter: each task drives one scenario
// and compares outputs against hand-computed values.
module tb_dma_priority_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  dma_priority_arbiter_if bus ();

  dma_priority_arbiter #(.NCH(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.DREQ = 4'b0000; bus.commandReg = 8'h00; bus.maskReg = 4'b0000;
    bus.requestReg = 4'b0000; bus.modeSel = 8'h55;
    bus.validDACK = 1'b0; bus.cycleDone = 1'b0; bus.eopIn = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    vectors++; if (bus.VALID_DREQ !== 4'b0000) begin miscompares++; $display("FAIL reset_valid: got %b want 0000", bus.VALID_DREQ); end
    vectors++; if (bus.activeCh !== 2'd0) begin miscompares++; $display("FAIL reset_active: got %0d want 0", bus.activeCh); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.DACK !== 4'b1111) begin miscompares++; $display("FAIL reset_dack: got %b want 1111", bus.DACK); end
    vectors++; if (bus.reqStatus !== 4'b0000) begin miscompares++; $display("FAIL reset_status: got %b want 0000", bus.reqStatus); end
    vectors++; if (bus.requestClr !== 4'b0000) begin miscompares++; $display("FAIL reset_clr: got %b want 0000", bus.requestClr); end
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_fixed_priority();
    do_reset();
    bus.DREQ = 4'b1010;
    tick();
    vectors++; if (bus.VALID_DREQ !== 4'b0000) begin miscompares++; $display("FAIL fixed_latency: got %b want 0000", bus.VALID_DREQ); end
    tick();
    vectors++; if (bus.VALID_DREQ !== 4'b0010) begin miscompares++; $display("FAIL fixed_valid: got %b want 0010", bus.VALID_DREQ); end
    vectors++; if (bus.activeCh !== 2'd1) begin miscompares++; $display("FAIL fixed_active: got %0d want 1", bus.activeCh); end
    bus.validDACK = 1'b1; tick(); bus.validDACK = 1'b0;
    vectors++; if (bus.DACK !== 4'b1101) begin miscompares++; $display("FAIL fixed_dack: got %b want 1101", bus.DACK); end
    bus.cycleDone = 1'b1; bus.DREQ = 4'b1000; tick(); bus.cycleDone = 1'b0;
    vectors++; if (bus.DACK !== 4'b1111) begin miscompares++; $display("FAIL fixed_dack_off: got %b want 1111", bus.DACK); end
    tick();
    vectors++; if (bus.VALID_DREQ !== 4'b1000 || bus.activeCh !== 2'd3) begin miscompares++; $display("FAIL fixed_next: got valid %b ch %0d want 1000 ch 3", bus.VALID_DREQ, bus.activeCh); end
    $display("test_fixed_priority done");
  endtask

  task automatic test_rotating();
    logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] want;
    do_reset();
    bus.commandReg = 8'h10;
    bus.DREQ = 4'b1111;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      want = 4'b0001 << order[i];
      vectors++; if (bus.activeCh !== order[i]) begin miscompares++; $display("FAIL rotate_ch[%0d]: got %0d want %0d", i, bus.activeCh, order[i]); end
      vectors++; if (bus.VALID_DREQ !== want) begin miscompares++; $display("FAIL rotate_valid[%0d]: got %b want %b", i, bus.VALID_DREQ, want); end
      bus.validDACK = 1'b1; tick(); bus.validDACK = 1'b0;
      bus.cycleDone = 1'b1; tick(); bus.cycleDone = 1'b0;
      tick();
    end
    $display("test_rotating done");
  endtask

  task automatic test_mask_software();
    do_reset();
    bus.DREQ = 4'b0001; bus.maskReg = 4'b0001;
    tick(); tick(); tick();
    vectors++; if (bus.busy !== 1'b0 || bus.VALID_DREQ !== 4'b0000) begin miscompares++; $display("FAIL mask_block: got busy %b valid %b want 0 0000", bus.busy, bus.VALID_DREQ); end
    vectors++; if (bus.reqStatus !== 4'b0000) begin miscompares++; $display("FAIL mask_status: got %b want 0000", bus.reqStatus); end
    bus.requestReg = 4'b0001;
    #1;
    vectors++; if (bus.reqStatus !== 4'b0001) begin miscompares++; $display("FAIL soft_status: got %b want 0001", bus.reqStatus); end
    tick();
    vectors++; if (bus.VALID_DREQ !== 4'b0001) begin miscompares++; $display("FAIL soft_valid: got %b want 0001", bus.VALID_DREQ); end
    bus.validDACK = 1'b1; tick(); bus.validDACK = 1'b0;
    vectors++; if (bus.requestClr !== 4'b0000) begin miscompares++; $display("FAIL soft_clr_early: got %b want 0000", bus.requestClr); end
    bus.eopIn = 1'b1; tick(); bus.eopIn = 1'b0; bus.requestReg = 4'b0000;
    vectors++; if (bus.requestClr !== 4'b0001 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL soft_eop: got clr %b busy %b want 0001 0", bus.requestClr, bus.busy); end
    tick();
    vectors++; if (bus.requestClr !== 4'b0000) begin miscompares++; $display("FAIL soft_clr_pulse: got %b want 0000", bus.requestClr); end
    $display("test_mask_software done");
  endtask

  task automatic test_block_mode();
    do_reset();
    bus.modeSel = 8'h20;
    bus.DREQ = 4'b0100;
    tick(); tick();
    vectors++; if (bus.VALID_DREQ !== 4'b0100 || bus.DACK !== 4'b1111) begin miscompares++; $display("FAIL block_grant: got valid %b dack %b want 0100 1111", bus.VALID_DREQ, bus.DACK); end
    bus.validDACK = 1'b1; tick(); bus.validDACK = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.cycleDone = 1'b1; tick(); bus.cycleDone = 1'b0;
      vectors++; if (bus.VALID_DREQ !== 4'b0100 || bus.DACK !== 4'b1011) begin miscompares++; $display("FAIL block_regrant[%0d]: got valid %b dack %b want 0100 1011", i, bus.VALID_DREQ, bus.DACK); end
      bus.validDACK = 1'b1; tick(); bus.validDACK = 1'b0;
      vectors++; if (bus.DACK !== 4'b1011 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL block_service[%0d]: got dack %b busy %b want 1011 1", i, bus.DACK, bus.busy); end
    end
    bus.cycleDone = 1'b1; bus.eopIn = 1'b1; tick(); bus.cycleDone = 1'b0; bus.eopIn = 1'b0;
    vectors++; if (bus.busy !== 1'b0 || bus.DACK !== 4'b1111) begin miscompares++; $display("FAIL block_end: got busy %b dack %b want 0 1111", bus.busy, bus.DACK); end
    vectors++; if (bus.requestClr !== 4'b0100) begin miscompares++; $display("FAIL block_clr: got %b want 0100", bus.requestClr); end
    $display("test_block_mode done");
  endtask

  task automatic test_demand_mode();
    do_reset();
    bus.modeSel = 8'h00;
    bus.DREQ = 4'b0010;
    tick(); tick();
    bus.validDACK = 1'b1; tick(); bus.validDACK = 1'b0;
    bus.cycleDone = 1'b1; tick(); bus.cycleDone = 1'b0;
    vectors++; if (bus.VALID_DREQ !== 4'b0010) begin miscompares++; $display("FAIL demand_hold: got %b want 0010", bus.VALID_DREQ); end
    bus.validDACK = 1'b1; tick(); bus.validDACK = 1'b0;
    bus.DREQ = 4'b0000; tick();
    bus.cycleDone = 1'b1; tick(); bus.cycleDone = 1'b0;
    vectors++; if (bus.busy !== 1'b0 || bus.requestClr !== 4'b0000) begin miscompares++; $display("FAIL demand_drop: got busy %b clr %b want 0 0000", bus.busy, bus.requestClr); end
    $display("test_demand_mode done");
  endtask

  task automatic test_disable();
    do_reset();
    bus.commandReg = 8'h04;
    bus.DREQ = 4'b0001;
    tick(); tick(); tick();
    vectors++; if (bus.busy !== 1'b0 || bus.reqStatus !== 4'b0001) begin miscompares++; $display("FAIL disable_hold: got busy %b status %b want 0 0001", bus.busy, bus.reqStatus); end
    bus.commandReg = 8'h00;
    tick();
    vectors++; if (bus.VALID_DREQ !== 4'b0001) begin miscompares++; $display("FAIL disable_release: got %b want 0001", bus.VALID_DREQ); end
    $display("test_disable done");
  endtask

  task automatic test_polarity();
    do_reset();
    bus.commandReg = 8'hC0;
    bus.DREQ = 4'b1110;
    tick(); tick();
    vectors++; if (bus.activeCh !== 2'd0 || bus.VALID_DREQ !== 4'b0001) begin miscompares++; $display("FAIL pol_grant: got ch %0d valid %b want 0 0001", bus.activeCh, bus.VALID_DREQ); end
    vectors++; if (bus.DACK !== 4'b0000) begin miscompares++; $display("FAIL pol_dack_idle: got %b want 0000", bus.DACK); end
    bus.validDACK = 1'b1; tick(); bus.validDACK = 1'b0;
    vectors++; if (bus.DACK !== 4'b0001) begin miscompares++; $display("FAIL pol_dack_on: got %b want 0001", bus.DACK); end
    bus.cycleDone = 1'b1; tick(); bus.cycleDone = 1'b0;
    vectors++; if (bus.DACK !== 4'b0000) begin miscompares++; $display("FAIL pol_dack_off: got %b want 0000", bus.DACK); end
    $display("test_polarity done");
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.DREQ = 4'b0001;
    tick(); tick();
    bus.validDACK = 1'b1; tick(); bus.validDACK = 1'b0;
    vectors++; if (bus.DACK !== 4'b1110) begin miscompares++; $display("FAIL async_pre: got %b want 1110", bus.DACK); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (bus.DACK !== 4'b1111) begin miscompares++; $display("FAIL async_dack: got %b want 1111", bus.DACK); end
    vectors++; if (bus.VALID_DREQ !== 4'b0000 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL async_state: got valid %b busy %b want 0000 0", bus.VALID_DREQ, bus.busy); end
    vectors++; if (bus.requestClr !== 4'b0000 || bus.activeCh !== 2'd0) begin miscompares++; $display("FAIL async_misc: got clr %b ch %0d want 0000 0", bus.requestClr, bus.activeCh); end
    #1;
    rst = 1'b0;
    tick();
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_rotating();
    test_mask_software();
    test_block_mode();
    test_demand_mode();
    test_disable();
    test_polarity();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Four-channel request arbiter and channel sequencer for the 8237A-compatible DMA controller. It samples DREQ3..0 and the software request register, applies mask, polarity, fixed/rotating priority and controller-disable from the command register, and presents one valid request at a time to the timing-control FSM. It holds the granted channel for the duration set by that channel's transfer mode (single, block, demand) and drives the DACK pins. Sits between the external DREQ/DACK pins, the register file and the timing-control state machine.

## Interface
Parameters:
- NCH, 4, number of channels (fixed at 4; not a supported override)

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- DREQ  in  4  raw channel request pins, polarity per commandReg[6]
- commandReg  in  8  [2] controller disable, [4] rotating priority, [6] DREQ active-low, [7] DACK active-high
- maskReg  in  4  1 = hardware request masked
- requestReg  in  4  software request bits (not maskable)
- modeSel  in  8  per-channel mode, ch n at [2n+1:2n]: 00 demand, 01 single, 10 block, 11 cascade
- validDACK  in  1  timing control in S1: transfer started
- cycleDone  in  1  one-cycle pulse at end of each transfer cycle (S4)
- eopIn  in  1  terminal count or external EOP seen this cycle
- VALID_DREQ  out  4  one-hot request presented to timing control
- activeCh  out  2  granted channel index
- busy  out  1  a channel is granted or in service
- DACK  out  4  acknowledge pins, polarity per commandReg[7]
- reqStatus  out  4  pending requests (to statusReg[7:4])
- requestClr  out  4  one-cycle pulse clearing the serviced requestReg bit

## Operation
- Sync: DREQ is registered once; hwReq = (commandReg[6] ? ~dreqQ : dreqQ) & ~maskReg. pending = hwReq | requestReg. reqStatus = pending.
- Priority: fixed → ch0 highest, ch3 lowest. Rotating → search starts at rotPtr, wraps mod 4; after a channel leaves SERVICE, rotPtr = ch+1 mod 4.
- FSM states: IDLE, GRANT, SERVICE.
  - IDLE: if commandReg[2]==0 and pending≠0 → latch winner into activeCh, go GRANT. Otherwise stay.
  - GRANT: VALID_DREQ = onehot(activeCh). validDACK → SERVICE. eopIn → IDLE (abort). Pending bit of activeCh dropped → IDLE (request withdrawn).
  - SERVICE: DACK[activeCh] active. At cycleDone: single/cascade → IDLE; block → IDLE only if eopIn, else GRANT; demand → IDLE if eopIn or channel's pending bit clear, else GRANT. eopIn in any SERVICE cycle → IDLE.
- On exit from SERVICE with eopIn set, requestClr[activeCh] pulses one cycle.
- Controller disable affects only new grants from IDLE; an in-flight grant completes.

## Timing
- Reset values: state IDLE, rotPtr 0, activeCh 0, VALID_DREQ 0, busy 0, reqStatus 0, requestClr 0, DACK 4'b1111 (inactive for commandReg reset value 0).
- DACK is registered and computed each cycle from next state and commandReg[7]; polarity change takes effect next edge.
- Latency: DREQ asserted before edge k → dreqQ at k → GRANT and VALID_DREQ at k+1.
- validDACK at edge k → DACK active after edge k; cycleDone at edge m → DACK inactive after m.
- IDLE entered from SERVICE always spends at least one cycle before re-arbitration; rotPtr update is visible to that arbitration.
- Simultaneous pending on all channels: winner strictly by current priority; no starvation in rotating mode.
- eopIn together with cycleDone: eop wins (IDLE, requestClr pulse).
- RESET asserted mid-SERVICE: all outputs to reset values immediately (async), no requestClr pulse.

## Structure
- dma_arb_pkg: state enum, mode encodings (MODE_DEMAND/SINGLE/BLOCK/CASCADE), commandReg bit index constants (CMD_DISABLE=2, CMD_ROTATE=4, CMD_DREQ_LOW=6, CMD_DACK_HIGH=7).
- Sub-module dma_priority_encoder: combinational, inputs pending[3:0], rotPtr[1:0], rotate; outputs winner[1:0], anyReq.

## Test plan
- Fixed priority, DREQ=4'b1010, maskReg=0: VALID_DREQ=4'b0010, activeCh=1 two cycles after DREQ; after cycleDone, ch3 granted.
- Rotating, DREQ=4'b1111 held, single mode: grant order 0,1,2,3,0; rotPtr advances each service.
- Mask: DREQ=4'b0001, maskReg=4'b0001 → no grant; requestReg=4'b0001 → ch0 granted, eopIn → requestClr=4'b0001 one pulse.
- Block mode ch2: three cycleDone pulses without eop keep DACK[2] held across GRANT/SERVICE; eopIn on third → IDLE, busy=0.
- Polarity: commandReg[6]=1, commandReg[7]=1, DREQ=4'b1110 → ch0 granted, DACK=4'b0001 in SERVICE.
- Async RESET during SERVICE → DACK=4'b1111, VALID_DREQ=0, busy=0 without clock edge.
